conv_line_feeder: RTL and testbench

- Upstream stage of ConvolutionAccelerator. Converts a valid/ready pixel stream from the processing system into the accelerator's input-buffer protocol: bufferInput, wr, newline, cStart.
- Respects the input-FIFO flags FULL_in and EMPTY_in.
- Frames raster-scan pixels using runtime width/height and reports frame completion.
- Replaces software bit-banging of wr/newline/cStart over GPIO.

---
 rtl/conv_accel_pkg.sv | 24 ++
 rtl/conv_rc_counter.sv | 50 +++++
 rtl/conv_line_feeder.sv | 98 +++++++++
 tb/tb_conv_line_feeder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_accel_pkg.sv
// Shared constants, FSM encoding and helpers for the convolution accelerator front/back ends.
package conv_accel_pkg;

    // Pixel width; must track the accelerator's bitLength.
    localparam int unsigned DATA_W  = 16;
    // Width of dimension fields and raster counters (max image 1023x1023).
    localparam int unsigned DIM_W   = 10;
    // Smallest legal image side for a 3x3 kernel.
    localparam int unsigned MIN_DIM = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StDone   = 3'd4
    } feeder_state_t;

    // True when both image dimensions can hold at least one full kernel window.
    function automatic logic dims_legal(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
        return (w >= DIM_W'(MIN_DIM)) && (h >= DIM_W'(MIN_DIM));
    endfunction

endpackage

// File: rtl/conv_rc_counter.sv
// Raster column/row counter: load latches the frame size and clears position,
// en advances one pixel in raster order.
module conv_rc_counter
    import conv_accel_pkg::*;
#(
    parameter int unsigned Width = DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] width,
    input  logic [Width-1:0] height,
    output logic             last_col,
    output logic             last_pixel
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] col_q, row_q;
    logic [Width-1:0] col_max_q, row_max_q;
    logic             last_row;

    assign last_col   = (col_q == col_max_q);
    assign last_row   = (row_q == row_max_q);
    assign last_pixel = last_col && last_row;

    // Position and limit registers; limits are frozen until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            col_max_q <= '0;
            row_max_q <= '0;
        end else if (load) begin
            col_q     <= '0;
            row_q     <= '0;
            col_max_q <= width - One;
            row_max_q <= height - One;
        end else if (en) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + One;
            end else begin
                col_q <= col_q + One;
            end
        end
    end

endmodule

// File: rtl/conv_line_feeder.sv
// Bridges a valid/ready pixel stream into the accelerator input-buffer protocol
// (bufferInput/wr/newline/cStart), framing pixels by a runtime width/height.
module conv_line_feeder
    import conv_accel_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              frame_start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] bufferInput,
    output logic              wr,
    output logic              newline,
    output logic              cStart,
    input  logic              FULL_in,
    input  logic              EMPTY_in,
    output logic              busy,
    output logic              frame_done,
    output logic              err_cfg
);

    feeder_state_t     state_q, state_d;
    logic [DATA_W-1:0] buf_q;
    logic              wr_q, newline_q, cstart_q, done_q, err_q;
    logic              cfg_ok, accept, load, last_col, last_pixel;

    assign cfg_ok = dims_legal(cfg_width, cfg_height);
    assign load   = (state_q == StIdle) && frame_start && cfg_ok;

    // Blocking on wr_q limits throughput to one pixel per two cycles so the
    // one-cycle FULL_in latency can never overrun the FIFO.
    assign s_ready = (state_q == StStream) && !FULL_in && !wr_q;
    assign accept  = s_valid && s_ready;

    conv_rc_counter #(
        .Width (DIM_W)
    ) u_rc_counter (
        .clk        (Clk),
        .rst_n      (Rst),
        .load       (load),
        .en         (accept),
        .width      (cfg_width),
        .height     (cfg_height),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (load) state_d = StStart;
            StStart:  state_d = StStream;
            StStream: if (accept && last_pixel) state_d = StDrain;
            // Ignore EMPTY_in while the final write is still in flight.
            StDrain:  if (EMPTY_in && !wr_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register and registered output pulses.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            wr_q      <= 1'b0;
            newline_q <= 1'b0;
            cstart_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= accept;
            newline_q <= accept && last_col;
            cstart_q  <= (state_d == StStart);
            done_q    <= (state_d == StDone);
            if (accept) begin
                buf_q <= s_data;
            end
            if (state_q == StIdle && frame_start) begin
                err_q <= !cfg_ok;
            end
        end
    end

    assign bufferInput = buf_q;
    assign wr          = wr_q;
    assign newline     = newline_q;
    assign cStart      = cstart_q;
    assign frame_done  = done_q;
    assign err_cfg     = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed self-checking bench for conv_line_feeder.
module tb_conv_line_feeder;
    import conv_accel_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              frame_start = 1'b0;
    logic [DIM_W-1:0]  cfg_width = '0;
    logic [DIM_W-1:0]  cfg_height = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] bufferInput;
    logic              wr, newline, cStart;
    logic              FULL_in = 1'b0;
    logic              EMPTY_in = 1'b0;
    logic              busy, frame_done, err_cfg;

    conv_line_feeder dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .frame_start (frame_start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .bufferInput (bufferInput),
        .wr          (wr),
        .newline     (newline),
        .cStart      (cStart),
        .FULL_in     (FULL_in),
        .EMPTY_in    (EMPTY_in),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_cfg     (err_cfg)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_bad = 0;

    // Observation log, filled just after each falling edge.
    int cyc = 0;
    int wr_n, nl_n, cs_n, fd_n, nl_bad, cs_cyc, fd_cyc;
    int wr_data_q[$];
    int wr_cyc_q[$];
    bit wr_nl_q[$];

    // Per-frame status from the stimulus driver.
    bit timed_out, ready_in_full, busy_drop;
    int empty_cyc;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        #1;
        if (wr === 1'b1) begin
            wr_n++;
            wr_data_q.push_back(int'(bufferInput));
            wr_cyc_q.push_back(cyc);
            wr_nl_q.push_back(newline === 1'b1);
        end
        if (newline === 1'b1) nl_n++;
        if (newline === 1'b1 && wr !== 1'b1) nl_bad++;
        if (cStart === 1'b1) begin cs_n++; cs_cyc = cyc; end
        if (frame_done === 1'b1) begin fd_n++; fd_cyc = cyc; end
    end

    task automatic clear_log();
        wr_n = 0; nl_n = 0; cs_n = 0; fd_n = 0; nl_bad = 0; cs_cyc = -100; fd_cyc = -100;
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_nl_q.delete();
    endtask

    // Drives one frame of pixels 1..w*h; optional FULL_in burst, mid-frame reset
    // and a stray frame_start during streaming. Returns one cycle after frame_done.
    task automatic run_frame(input int w, input int h, input int full_after, input int full_len,
                             input int empty_delay, input int rst_after, input bit fs_mid);
        int  sent, full_cnt, k, total;
        bit  hs, fired_fs;
        total = w * h; sent = 0; full_cnt = 0; k = -1; hs = 0; fired_fs = 0;
        timed_out = 1; ready_in_full = 0; busy_drop = 0; empty_cyc = -1000;
        @(negedge Clk);
        clear_log();
        cfg_width = 10'(w); cfg_height = 10'(h);
        frame_start = 1'b1; s_valid = 1'b1; s_data = 16'd1; EMPTY_in = 1'b0; FULL_in = 1'b0;
        @(negedge Clk);
        frame_start = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (fd_n > 0) begin
                timed_out = 0;
                return;
            end
            if (hs) begin sent++; s_data = s_data + 16'd1; hs = 0; end
            if (rst_after > 0 && sent == rst_after) begin
                Rst = 1'b0; s_valid = 1'b0; FULL_in = 1'b0;
                repeat (2) @(negedge Clk);
                Rst = 1'b1;
                timed_out = 0;
                return;
            end
            if (sent >= total) begin s_valid = 1'b0; k++; end
            if (k >= 0 && k <= empty_delay && busy !== 1'b1) busy_drop = 1;
            if (k == empty_delay) begin EMPTY_in = 1'b1; empty_cyc = cyc; end
            if (fs_mid && !fired_fs && sent == 3) begin
                frame_start = 1'b1; cfg_width = 10'd7; fired_fs = 1;
            end else begin
                frame_start = 1'b0;
            end
            if (full_after > 0 && sent >= full_after && full_cnt < full_len) begin
                FULL_in = 1'b1; full_cnt++;
            end else begin
                FULL_in = 1'b0;
            end
            #1;
            if (FULL_in && s_ready !== 1'b0) ready_in_full = 1;
            hs = s_valid && (s_ready === 1'b1);
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; s_valid = 1'b1; frame_start = 1'b1; cfg_width = 10'd4; cfg_height = 10'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (s_ready !== 1'b0) begin
                n_bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
            end
            n_checks++;
            if ({bufferInput, wr, newline, cStart, frame_done, err_cfg} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h want 0",
                         {bufferInput, wr, newline, cStart, frame_done, err_cfg});
            end
        end
        Rst = 1'b1; s_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_nominal();
        run_frame(4, 3, 0, 0, 2, 0, 0);
        n_checks++;
        if (timed_out) begin n_bad++; $display("FAIL nominal_timeout: got 1 want 0"); end
        n_checks++;
        if (wr_n !== 12) begin n_bad++; $display("FAIL nominal_wr_count: got %0d want 12", wr_n); end
        for (int i = 0; i < wr_data_q.size() && i < 12; i++) begin
            n_checks++;
            if (wr_data_q[i] !== i + 1) begin
                n_bad++; $display("FAIL nominal_data[%0d]: got %0d want %0d", i, wr_data_q[i], i + 1);
            end
            n_checks++;
            if (wr_nl_q[i] !== ((i + 1) % 4 == 0)) begin
                n_bad++; $display("FAIL nominal_newline[%0d]: got %b want %b", i, wr_nl_q[i],
                                  ((i + 1) % 4 == 0));
            end
        end
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            n_checks++;
            if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 2) begin
                n_bad++; $display("FAIL nominal_spacing[%0d]: got %0d want 2", i,
                                  wr_cyc_q[i] - wr_cyc_q[i-1]);
            end
        end
        n_checks++;
        if (cs_n !== 1) begin n_bad++; $display("FAIL nominal_cstart_count: got %0d want 1", cs_n); end
        if (wr_cyc_q.size() > 0) begin
            n_checks++;
            if (wr_cyc_q[0] - cs_cyc !== 2) begin
                n_bad++; $display("FAIL nominal_cstart_lead: got %0d want 2", wr_cyc_q[0] - cs_cyc);
            end
        end
        n_checks++;
        if (fd_n !== 1) begin n_bad++; $display("FAIL nominal_done_count: got %0d want 1", fd_n); end
        n_checks++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL nominal_busy_after: got %b want 0", busy); end
        n_checks++;
        if (nl_bad !== 0) begin n_bad++; $display("FAIL nominal_newline_alone: got %0d want 0", nl_bad); end
    endtask

    task automatic test_backpressure();
        run_frame(4, 3, 5, 5, 2, 0, 0);
        n_checks++;
        if (wr_n !== 12) begin n_bad++; $display("FAIL bp_wr_count: got %0d want 12", wr_n); end
        for (int i = 0; i < wr_data_q.size() && i < 12; i++) begin
            n_checks++;
            if (wr_data_q[i] !== i + 1) begin
                n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, wr_data_q[i], i + 1);
            end
        end
        n_checks++;
        if (ready_in_full) begin n_bad++; $display("FAIL bp_ready_when_full: got 1 want 0"); end
        if (wr_cyc_q.size() > 5) begin
            n_checks++;
            if (wr_cyc_q[5] - wr_cyc_q[4] !== 6) begin
                n_bad++; $display("FAIL bp_stall_gap: got %0d want 6", wr_cyc_q[5] - wr_cyc_q[4]);
            end
        end
        n_checks++;
        if (fd_n !== 1 || timed_out) begin
            n_bad++; $display("FAIL bp_done: got %0d want 1", fd_n);
        end
    endtask

    task automatic test_illegal_cfg();
        @(negedge Clk);
        clear_log();
        cfg_width = 10'd2; cfg_height = 10'd5; frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (4) @(negedge Clk);
        n_checks++;
        if (err_cfg !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", err_cfg); end
        n_checks++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy: got %b want 0", busy); end
        n_checks++;
        if (cs_n !== 0 || wr_n !== 0) begin
            n_bad++; $display("FAIL illegal_activity: got cs=%0d wr=%0d want 0 0", cs_n, wr_n);
        end
        run_frame(5, 5, 0, 0, 2, 0, 0);
        n_checks++;
        if (err_cfg !== 1'b0) begin n_bad++; $display("FAIL legal_err_clear: got %b want 0", err_cfg); end
        n_checks++;
        if (wr_n !== 25) begin n_bad++; $display("FAIL legal_wr_count: got %0d want 25", wr_n); end
        n_checks++;
        if (fd_n !== 1 || timed_out) begin n_bad++; $display("FAIL legal_done: got %0d want 1", fd_n); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(4, 4, 0, 0, 2, 7, 0);
        repeat (6) @(negedge Clk);
        n_checks++;
        if (wr_n !== 7) begin n_bad++; $display("FAIL midrst_wr_count: got %0d want 7", wr_n); end
        n_checks++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++;
        if (bufferInput !== '0) begin
            n_bad++; $display("FAIL midrst_buffer: got %0d want 0", bufferInput);
        end
        run_frame(4, 4, 0, 0, 2, 0, 0);
        n_checks++;
        if (wr_n !== 16) begin n_bad++; $display("FAIL restart_wr_count: got %0d want 16", wr_n); end
        for (int i = 0; i < wr_nl_q.size() && i < 16; i++) begin
            n_checks++;
            if (wr_nl_q[i] !== ((i + 1) % 4 == 0)) begin
                n_bad++; $display("FAIL restart_newline[%0d]: got %b want %b", i, wr_nl_q[i],
                                  ((i + 1) % 4 == 0));
            end
        end
        n_checks++;
        if (fd_n !== 1 || timed_out) begin n_bad++; $display("FAIL restart_done: got %0d want 1", fd_n); end
    endtask

    task automatic test_ignore_and_drain();
        run_frame(3, 3, 0, 0, 10, 0, 1);
        n_checks++;
        if (cs_n !== 1) begin n_bad++; $display("FAIL drain_cstart_count: got %0d want 1", cs_n); end
        n_checks++;
        if (wr_n !== 9) begin n_bad++; $display("FAIL drain_wr_count: got %0d want 9", wr_n); end
        n_checks++;
        if (nl_n !== 3) begin n_bad++; $display("FAIL drain_newline_count: got %0d want 3", nl_n); end
        for (int i = 0; i < wr_nl_q.size() && i < 9; i++) begin
            n_checks++;
            if (wr_nl_q[i] !== ((i + 1) % 3 == 0)) begin
                n_bad++; $display("FAIL drain_newline[%0d]: got %b want %b", i, wr_nl_q[i],
                                  ((i + 1) % 3 == 0));
            end
        end
        n_checks++;
        if (busy_drop) begin n_bad++; $display("FAIL drain_busy_held: got 1 want 0"); end
        n_checks++;
        if (fd_cyc - empty_cyc !== 1) begin
            n_bad++; $display("FAIL drain_done_latency: got %0d want 1", fd_cyc - empty_cyc);
        end
        n_checks++;
        if (fd_n !== 1 || timed_out) begin n_bad++; $display("FAIL drain_done: got %0d want 1", fd_n); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_nominal();
        test_backpressure();
        test_illegal_cfg();
        test_reset_mid_frame();
        test_ignore_and_drain();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
